// File: rtl/if_id_hazard_pkg.sv
// Shared pipeline definitions for the IF/ID register and load-use hazard logic.
package if_id_hazard_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_WIDTH = 16;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  localparam logic [XLEN-1:0] NOP = 32'h0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  function automatic logic [REG_W-1:0] rs_of(input logic [XLEN-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [REG_W-1:0] rt_of(input logic [XLEN-1:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/if_id_hazard_if.sv
// Front-end bus between fetch/ID/EX control and the IF/ID hazard block.
interface if_id_hazard_if
  import if_id_hazard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_WIDTH
);
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  instr_i;
  logic             flush_i;
  logic             mem_stall_i;
  logic             id_ex_memread_i;
  logic [REG_W-1:0] id_ex_rt_i;

  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  instr_o;
  logic             valid_o;
  logic             pc_write_o;
  logic             bubble_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output pc_i, instr_i, flush_i, mem_stall_i, id_ex_memread_i, id_ex_rt_i,
    input  pc_o, instr_o, valid_o, pc_write_o, bubble_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  pc_i, instr_i, flush_i, mem_stall_i, id_ex_memread_i, id_ex_rt_i,
    output pc_o, instr_o, valid_o, pc_write_o, bubble_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/if_id_hazard_load_use_detect.sv
// Combinational load-use detector: the EX-stage load targets a register ID reads.
module load_use_detect
  import if_id_hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             valid_i,
  input  logic             memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic             lu_c
);
  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign lu_c = memread_i && (ex_rt_i != REG_W'(0)) && valid_i &&
                ((ex_rt_i == rs_i) || (ex_rt_i == rt_i));
endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use bubble FSM, flush, memory stall and
// a saturating bubble counter.
module if_id_hazard
  import if_id_hazard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_WIDTH
)(
  input  logic               clk_i,
  input  logic               rst_i,
  if_id_hazard_if.slave      bus
);
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  instr_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  state_e           state_q;

  logic lu_c;
  logic lu_eff_c;
  logic pc_write_c;
  logic bubble_c;
  logic stall_c;

  load_use_detect u_lu (
    .rs_i      (rs_of(instr_q)),
    .rt_i      (rt_of(instr_q)),
    .valid_i   (valid_q),
    .memread_i (bus.id_ex_memread_i),
    .ex_rt_i   (bus.id_ex_rt_i),
    .lu_c      (lu_c)
  );

  // The instruction held through a bubble is not re-checked.
  assign lu_eff_c = lu_c && (state_q == ST_RUN);

  // Front-end control, priority: reset, memory stall, flush, load-use.
  always_comb begin
    pc_write_c = 1'b1;
    bubble_c   = 1'b0;
    stall_c    = 1'b0;
    if (rst_i) begin
      pc_write_c = 1'b1;
    end else if (bus.mem_stall_i) begin
      pc_write_c = 1'b0;
      stall_c    = 1'b1;
    end else if (bus.flush_i) begin
      pc_write_c = 1'b1;
    end else if (lu_eff_c) begin
      pc_write_c = 1'b0;
      bubble_c   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else if (bus.mem_stall_i) begin
      state_q <= state_q;
    end else if (bus.flush_i) begin
      pc_q    <= bus.pc_i;
      instr_q <= NOP;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
    end else if (lu_eff_c) begin
      state_q <= ST_BUBBLE;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      pc_q    <= bus.pc_i;
      instr_q <= bus.instr_i;
      valid_q <= 1'b1;
      state_q <= ST_RUN;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.instr_o     = instr_q;
  assign bus.valid_o     = valid_q;
  assign bus.stall_cnt_o = cnt_q;
  assign bus.pc_write_o  = pc_write_c;
  assign bus.bubble_o    = bubble_c;
  assign bus.stall_o     = stall_c;
endmodule

// File: tb/tb_if_id_hazard.sv
// Scoreboard bench for if_id_hazard; a narrowed counter keeps saturation short.
module tb_if_id_hazard;
  import if_id_hazard_pkg::*;

  localparam int unsigned CW      = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;

  localparam logic [31:0] IA = 32'h012A4020;  // rs=9  rt=10
  localparam logic [31:0] IB = 32'h01095020;  // rs=8  rt=9
  localparam logic [31:0] IC = 32'h00001020;  // rs=0  rt=0

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        pcw;
    logic        bub;
    logic        stall;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  if_id_hazard_if #(.CNT_W(CW)) bus ();

  if_id_hazard #(.CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic r, input logic f, input logic m,
                      input logic mr, input logic [4:0] rt,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] epc, input logic [31:0] eins,
                      input logic ev, input logic epw, input logic eb, input logic es,
                      input int ec);
    exp_t e;
    rst                 = r;
    bus.flush_i         = f;
    bus.mem_stall_i     = m;
    bus.id_ex_memread_i = mr;
    bus.id_ex_rt_i      = rt;
    bus.pc_i            = pc;
    bus.instr_i         = ins;
    e.name = nm; e.pc = epc; e.instr = eins; e.valid = ev;
    e.pcw = epw; e.bub = eb; e.stall = es; e.cnt = ec;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the visible outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (bus.pc_o !== e.pc || bus.instr_o !== e.instr || bus.valid_o !== e.valid ||
          bus.pc_write_o !== e.pcw || bus.bubble_o !== e.bub || bus.stall_o !== e.stall ||
          int'(bus.stall_cnt_o) != e.cnt) begin
        bad++;
        $display("FAIL %s: got pc=%h instr=%h v=%b pcw=%b bub=%b st=%b cnt=%0d exp pc=%h instr=%h v=%b pcw=%b bub=%b st=%b cnt=%0d",
                 e.name, bus.pc_o, bus.instr_o, bus.valid_o, bus.pc_write_o, bus.bubble_o,
                 bus.stall_o, bus.stall_cnt_o, e.pc, e.instr, e.valid, e.pcw, e.bub, e.stall, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.mem_stall_i = 1'b0; bus.id_ex_memread_i = 1'b0;
    bus.id_ex_rt_i = '0; bus.pc_i = '0; bus.instr_i = '0;
    @(posedge clk);
    #1;
    //    name               r  f  m  mr rt  pc      instr  epc     einstr v  pw bu st cnt
    step("reset",           1, 1, 1, 1, 9, 32'd0,  32'h0, 32'd0,  32'h0, 0, 1, 0, 0, 0);
    step("first_load",      0, 0, 0, 0, 0, 32'd4,  IA,    32'd0,  32'h0, 0, 1, 0, 0, 0);
    step("normal",          0, 0, 0, 0, 0, 32'd8,  IB,    32'd4,  IA,    1, 1, 0, 0, 0);
    step("lu_on_rt",        0, 0, 0, 1, 9, 32'd12, IC,    32'd8,  IB,    1, 0, 1, 0, 0);
    step("bubble_no_recheck",0,0, 0, 1, 9, 32'd12, IC,    32'd8,  IB,    1, 1, 0, 0, 1);
    step("zero_reg",        0, 0, 0, 1, 0, 32'd16, IA,    32'd12, IC,    1, 1, 0, 0, 1);
    step("lu_on_rs",        0, 0, 0, 1, 9, 32'd20, IB,    32'd16, IA,    1, 0, 1, 0, 1);
    step("mstall_bubble1",  0, 0, 1, 1, 9, 32'd20, IB,    32'd16, IA,    1, 0, 0, 1, 2);
    step("mstall_bubble2",  0, 0, 1, 1, 9, 32'd20, IB,    32'd16, IA,    1, 0, 0, 1, 2);
    step("mstall_bubble3",  0, 0, 1, 1, 9, 32'd20, IB,    32'd16, IA,    1, 0, 0, 1, 2);
    step("bubble_after_ms", 0, 0, 0, 0, 0, 32'd20, IB,    32'd16, IA,    1, 1, 0, 0, 2);
    step("mstall_over_lu",  0, 0, 1, 1, 9, 32'd24, IA,    32'd20, IB,    1, 0, 0, 1, 2);
    step("flush_over_lu",   0, 1, 0, 1, 9, 32'd24, IA,    32'd20, IB,    1, 1, 0, 0, 2);
    step("after_flush",     0, 0, 0, 1, 9, 32'd28, IB,    32'd24, 32'h0, 0, 1, 0, 0, 2);
    step("lu_again",        0, 0, 0, 1, 9, 32'd32, IC,    32'd28, IB,    1, 0, 1, 0, 2);
    step("flush_in_bubble", 0, 1, 0, 1, 9, 32'd36, IA,    32'd28, IB,    1, 1, 0, 0, 3);
    step("post_flush_bub",  0, 0, 0, 0, 0, 32'd40, IB,    32'd36, 32'h0, 0, 1, 0, 0, 3);
    step("run_after_flush", 0, 0, 0, 1, 9, 32'd44, IC,    32'd40, IB,    1, 0, 1, 0, 3);
    step("rst_mid_bubble",  1, 1, 1, 1, 9, 32'd44, IC,    32'd40, IB,    1, 1, 0, 0, 4);
    step("post_rst",        0, 0, 0, 1, 9, 32'd4,  IB,    32'd0,  32'h0, 0, 1, 0, 0, 0);
    step("run_after_rst",   0, 0, 0, 1, 9, 32'd8,  IB,    32'd4,  IB,    1, 0, 1, 0, 0);

    // Alternate bubble / load-use cycles well past the counter limit.
    for (int k = 0; k < CNT_MAX + 4; k++) begin
      c = (k + 1 > CNT_MAX) ? CNT_MAX : k + 1;
      step("sat_bubble", 0, 0, 0, 1, 9, 32'd8, IB, (k == 0) ? 32'd4 : 32'd8, IB, 1, 1, 0, 0, c);
      step("sat_lu",     0, 0, 0, 1, 9, 32'd8, IB, 32'd8, IB, 1, 0, 1, 0, c);
    end
    step("sat_hold",        0, 0, 1, 1, 9, 32'd8,  IB,    32'd8,  IB,    1, 0, 0, 1, CNT_MAX);
    step("sat_rst_bubble",  1, 0, 0, 1, 9, 32'd8,  IB,    32'd8,  IB,    1, 1, 0, 0, CNT_MAX);
    step("sat_post_rst",    0, 0, 0, 1, 9, 32'd12, IB,    32'd0,  32'h0, 0, 1, 0, 0, 0);
    step("sat_run_lu",      0, 0, 0, 1, 9, 32'd16, IA,    32'd12, IB,    1, 0, 1, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_hazard.md
IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 SHALL have ports: clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have pc_i, input, 32, PC+4 of the fetched instruction.
REQ-004 SHALL have instr_i, input, 32, the fetched instruction word.
REQ-005 SHALL have flush_i, input, 1, branch taken in ID; discards the fetched instruction.
REQ-006 SHALL have mem_stall_i, input, 1, memory not ready; freezes the front end and ID/EX.
REQ-007 SHALL have id_ex_memread_i, input, 1, the Memory_read output of the ID/EX register.
REQ-008 SHALL have id_ex_rt_i, input, 5, the RTaddr output of the ID/EX register.
REQ-009 SHALL have pc_o, output, 32, registered PC+4 for ID.
REQ-010 SHALL have instr_o, output, 32, registered instruction for ID.
REQ-011 SHALL have valid_o, output, 1, instr_o is a real instruction, not a NOP or bubble.
REQ-012 SHALL have pc_write_o, output, 1, PC register enable.
REQ-013 SHALL have bubble_o, output, 1, zero all control inputs of ID/EX this cycle.
REQ-014 SHALL have stall_o, output, 1, drives the stall_i input of the ID/EX register.
REQ-015 SHALL have stall_cnt_o, output, 16, saturating count of load-use bubble cycles.

Function
REQ-016 SHALL define the ID operands as rs = instr_o[25:21] and rt = instr_o[20:16].
REQ-017 SHALL flag a load-use hazard (lu) when id_ex_memread_i=1, id_ex_rt_i!=0, valid_o=1, and id_ex_rt_i equals rs or rt.
REQ-018 SHALL apply per-cycle priority: rst_i, then mem_stall_i, then flush_i, then lu, then normal.
REQ-019 On mem_stall_i: pc_write_o=0, stall_o=1, bubble_o=0; pc_o, instr_o, valid_o, FSM and counter all hold.
REQ-020 On flush_i (no mem_stall_i): at the next edge, instr_o=32'h0 and valid_o=0; pc_o<=pc_i; pc_write_o=1.
REQ-021 flush_i SHALL take priority over a simultaneous lu; no bubble and no counter increment in that cycle.
REQ-022 On lu in state RUN: pc_write_o=0, bubble_o=1, stall_o=0; IF/ID holds; FSM goes to BUBBLE; stall_cnt_o increments.
REQ-023 In normal operation: pc_write_o=1; at the edge pc_o<=pc_i, instr_o<=instr_i, valid_o<=1.
REQ-024 SHALL have FSM states RUN and BUBBLE; BUBBLE lasts exactly one non-frozen cycle, then returns to RUN.
REQ-025 In BUBBLE, lu SHALL NOT be re-evaluated, so no back-to-back bubble for the same instruction; behaviour is normal, or flush if flush_i=1.
REQ-026 mem_stall_i in BUBBLE SHALL hold the FSM in BUBBLE.
REQ-027 pc_write_o, bubble_o and stall_o SHALL be combinational from current state and inputs; all other outputs are registered.
REQ-028 stall_cnt_o SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-029 On rst_i=1 at an edge: pc_o=0, instr_o=0, valid_o=0, FSM=RUN, stall_cnt_o=0.
REQ-030 While rst_i=1: pc_write_o=1, bubble_o=0, stall_o=0, and mem_stall_i, flush_i and lu are ignored.
REQ-031 Reset asserted mid-bubble SHALL abort the bubble; the first post-reset cycle is RUN.

Structure
REQ-032 A shared pipeline package SHALL hold: the NOP constant (32'h0), the rs/rt field bit positions, the FSM state encoding (RUN=0, BUBBLE=1), and the counter width (16).
REQ-033 Hazard detection SHALL be a sub-module load_use_detect (purely combinational lu output); the register, FSM and counter stay in if_id_hazard.

Verification
REQ-034 Normal: reset, then pc_i=4, instr_i=32'h012A4020 -> next cycle pc_o=4, instr_o=32'h012A4020, valid_o=1, pc_write_o=1.
REQ-035 Load-use: instr_o has rs=9, id_ex_memread_i=1, id_ex_rt_i=9 -> bubble_o=1, pc_write_o=0, IF/ID held one cycle, stall_cnt_o=1, then RUN.
REQ-036 Zero register: id_ex_rt_i=0, id_ex_memread_i=1, instr_o has rs=0 -> no bubble, pc_write_o=1.
REQ-037 Flush with hazard: flush_i=1 and a load-use hazard in the same cycle -> instr_o=0, valid_o=0, bubble_o=0, stall_cnt_o unchanged.
REQ-038 Memory stall: mem_stall_i=1 for 3 cycles during BUBBLE -> stall_o=1 and outputs frozen each of those cycles; after release, one BUBBLE cycle completes, then RUN.
REQ-039 Saturation: force 65537 hazards -> stall_cnt_o=16'hFFFF; a reset pulse mid-bubble -> stall_cnt_o=0, valid_o=0, FSM=RUN.
